pulse_channel_voice: RTL and testbench

- Sits directly downstream of the channel note sequencer.
- Consumes the sequencer's phase delta, duty ("top") and envelope, and produces one signed pulse-wave sample per sample strobe for the mixer.
- Contains a phase accumulator, a duty register that changes only at phase wrap (glitch-free), rest-note muting, and a 2-stage output pipeline.

---
 rtl/pulse_channel_voice.sv | 135 +++++++++++++
 tb/tb_pulse_channel_voice.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pulse_channel_voice.sv
// pulse_channel_voice: pulse-wave voice for one sequencer channel.
// Advances a phase accumulator once per sample strobe and compares its top
// bits against the active duty threshold. The result is emitted as a signed
// +/-envelope sample two cycles after the strobe. Duty requests are held in a
// pending register and take effect only at a phase wrap or on a rest strobe,
// so the duty never changes part-way through a period.
//
// Handshake: i_sample_stb, i_top_valid, o_sample_valid and o_wrap are
// single-cycle qualifiers with no backpressure. A strobe is consumed in the
// cycle it is high, and o_sample_valid/o_wrap pulse for exactly one cycle,
// two cycles later.
module pulse_channel_voice #(
    parameter int PHASE_WIDTH  = 32,
    parameter int DUTY_WIDTH   = 8,
    parameter int ENV_WIDTH    = 9,
    parameter int SAMPLE_WIDTH = ENV_WIDTH + 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_sample_stb,
    input  logic [PHASE_WIDTH-1:0]  i_phase_delta,
    input  logic [DUTY_WIDTH-1:0]   i_top,
    input  logic                    i_top_valid,
    input  logic [ENV_WIDTH-1:0]    i_envelope,
    output logic [SAMPLE_WIDTH-1:0] o_sample,
    output logic                    o_sample_valid,
    output logic                    o_wrap
);

    // 50% duty: only the MSB of the threshold is set.
    localparam logic [DUTY_WIDTH-1:0] DUTY_RESET = {1'b1, {(DUTY_WIDTH-1){1'b0}}};

    // Phase and duty state
    logic [PHASE_WIDTH-1:0]  acc_q, acc_d;
    logic [DUTY_WIDTH-1:0]   duty_active_q, duty_active_d;
    logic [DUTY_WIDTH-1:0]   duty_pend_q, duty_pend_d;
    logic                    pend_flag_q, pend_flag_d;

    // Stage 1 registers (captured on the strobe)
    logic                    s1_valid_q, s1_valid_d;
    logic                    s1_mute_q, s1_mute_d;
    logic                    s1_wrap_q, s1_wrap_d;
    logic [ENV_WIDTH-1:0]    s1_env_q, s1_env_d;

    // Output registers
    logic [SAMPLE_WIDTH-1:0] out_sample_q, out_sample_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_wrap_q, out_wrap_d;

    logic [PHASE_WIDTH:0]    acc_sum;
    logic                    apply_duty;
    logic                    high;
    logic [SAMPLE_WIDTH-1:0] env_ext;

    // Stage 0: advance the accumulator, promote pending duty at wrap/rest, capture duty requests
    always_comb begin
        acc_sum       = {1'b0, acc_q} + {1'b0, i_phase_delta};
        acc_d         = acc_q;
        s1_valid_d    = 1'b0;
        s1_mute_d     = s1_mute_q;
        s1_wrap_d     = s1_wrap_q;
        s1_env_d      = s1_env_q;
        apply_duty    = 1'b0;
        if (i_sample_stb) begin
            s1_valid_d = 1'b1;
            s1_env_d   = i_envelope;
            if (i_phase_delta == '0) begin
                acc_d      = '0;
                s1_mute_d  = 1'b1;
                s1_wrap_d  = 1'b0;
                apply_duty = pend_flag_q;
            end else begin
                acc_d      = acc_sum[PHASE_WIDTH-1:0];
                s1_mute_d  = 1'b0;
                s1_wrap_d  = acc_sum[PHASE_WIDTH];
                apply_duty = pend_flag_q & acc_sum[PHASE_WIDTH];
            end
        end
        // A request arriving alongside a promotion lands in pending only.
        duty_active_d = apply_duty ? duty_pend_q : duty_active_q;
        duty_pend_d   = i_top_valid ? i_top : duty_pend_q;
        pend_flag_d   = i_top_valid ? 1'b1 : (apply_duty ? 1'b0 : pend_flag_q);
    end

    // Stages 1-2: compare phase against the (already updated) duty and form the signed sample
    always_comb begin
        high         = (acc_q[PHASE_WIDTH-1 -: DUTY_WIDTH] < duty_active_q);
        env_ext      = {{(SAMPLE_WIDTH-ENV_WIDTH){1'b0}}, s1_env_q};
        out_sample_d = out_sample_q;
        out_valid_d  = s1_valid_q;
        out_wrap_d   = s1_valid_q & s1_wrap_q;
        if (s1_valid_q) begin
            if (s1_mute_q)
                out_sample_d = '0;
            else if (high)
                out_sample_d = env_ext;
            else
                out_sample_d = {SAMPLE_WIDTH{1'b0}} - env_ext;
        end
    end

    // State and pipeline registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q         <= '0;
            duty_active_q <= DUTY_RESET;
            duty_pend_q   <= DUTY_RESET;
            pend_flag_q   <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_mute_q     <= 1'b0;
            s1_wrap_q     <= 1'b0;
            s1_env_q      <= '0;
            out_sample_q  <= '0;
            out_valid_q   <= 1'b0;
            out_wrap_q    <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            duty_active_q <= duty_active_d;
            duty_pend_q   <= duty_pend_d;
            pend_flag_q   <= pend_flag_d;
            s1_valid_q    <= s1_valid_d;
            s1_mute_q     <= s1_mute_d;
            s1_wrap_q     <= s1_wrap_d;
            s1_env_q      <= s1_env_d;
            out_sample_q  <= out_sample_d;
            out_valid_q   <= out_valid_d;
            out_wrap_q    <= out_wrap_d;
        end
    end

    assign o_sample       = out_sample_q;
    assign o_sample_valid = out_valid_q;
    assign o_wrap         = out_wrap_q;

endmodule

// File: tb/tb_pulse_channel_voice.sv
// Directed bench for pulse_channel_voice with hand-computed expected samples.
module tb_pulse_channel_voice;

    logic        clk;
    logic        rst_n;
    logic        stb;
    logic [31:0] delta;
    logic [7:0]  top;
    logic        top_valid;
    logic [8:0]  env;
    logic [9:0]  o_sample;
    logic        o_sample_valid;
    logic        o_wrap;

    int n_cmp;
    int n_err;

    localparam logic [9:0] P100 = 10'h064;
    localparam logic [9:0] N100 = 10'h39C;
    localparam logic [9:0] P50  = 10'h032;
    localparam logic [9:0] N50  = 10'h3CE;
    localparam logic [9:0] P511 = 10'h1FF;
    localparam logic [9:0] N511 = 10'h201;
    localparam logic [31:0] Q   = 32'h4000_0000;

    pulse_channel_voice dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_sample_stb   (stb),
        .i_phase_delta  (delta),
        .i_top          (top),
        .i_top_valid    (top_valid),
        .i_envelope     (env),
        .o_sample       (o_sample),
        .o_sample_valid (o_sample_valid),
        .o_wrap         (o_wrap)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0; stb = 1'b0; top_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check({tag, "_rst_sample"}, o_sample, 0);
        check({tag, "_rst_valid"}, o_sample_valid, 0);
        check({tag, "_rst_wrap"}, o_wrap, 0);
    endtask

    task automatic pulse_top(input logic [7:0] t);
        @(negedge clk);
        top_valid = 1'b1; top = t;
        @(negedge clk);
        top_valid = 1'b0;
    endtask

    // One strobe; checks valid timing (exactly 2 cycles), sample, wrap, and hold.
    task automatic do_sample(input string tag, input logic [31:0] d, input logic [8:0] e,
                             input logic tv, input logic [7:0] t,
                             input logic [9:0] exp_s, input logic exp_w);
        @(negedge clk);
        stb = 1'b1; delta = d; env = e; top_valid = tv; top = t;
        @(negedge clk);
        stb = 1'b0; top_valid = 1'b0;
        delta = $urandom; env = 9'($urandom_range(0, 511));
        check({tag, "_early_valid"}, o_sample_valid, 0);
        @(negedge clk);
        check({tag, "_valid"}, o_sample_valid, 1);
        check({tag, "_sample"}, o_sample, exp_s);
        check({tag, "_wrap"}, o_wrap, exp_w);
        @(negedge clk);
        check({tag, "_valid_drop"}, o_sample_valid, 0);
        check({tag, "_hold"}, o_sample, exp_s);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; stb = 1'b0; delta = '0; top = '0; top_valid = 1'b0; env = '0;

        // 1: reset state and first sample with default 50% duty
        apply_reset("s1");
        do_sample("s1_first", Q, 9'd100, 1'b0, 8'h00, P100, 1'b0);

        // 2: eight strobes from phase 0, duty 'h80
        apply_reset("s2");
        do_sample("s2_1", Q, 9'd100, 1'b0, 8'h00, P100, 1'b0);
        do_sample("s2_2", Q, 9'd100, 1'b0, 8'h00, N100, 1'b0);
        do_sample("s2_3", Q, 9'd100, 1'b0, 8'h00, N100, 1'b0);
        do_sample("s2_4", Q, 9'd100, 1'b0, 8'h00, P100, 1'b1);
        do_sample("s2_5", Q, 9'd100, 1'b0, 8'h00, P100, 1'b0);
        do_sample("s2_6", Q, 9'd100, 1'b0, 8'h00, N100, 1'b0);
        do_sample("s2_7", Q, 9'd100, 1'b0, 8'h00, N100, 1'b0);
        do_sample("s2_8", Q, 9'd100, 1'b0, 8'h00, P100, 1'b1);

        // 3: mid-period duty request applies only at the next wrap
        apply_reset("s3");
        do_sample("s3_1", Q, 9'd100, 1'b0, 8'h00, P100, 1'b0);
        pulse_top(8'h20);
        do_sample("s3_2", Q, 9'd100, 1'b0, 8'h00, N100, 1'b0);
        do_sample("s3_3", Q, 9'd100, 1'b0, 8'h00, N100, 1'b0);
        do_sample("s3_4", Q, 9'd100, 1'b0, 8'h00, P100, 1'b1);
        do_sample("s3_5", Q, 9'd100, 1'b0, 8'h00, N100, 1'b0);
        do_sample("s3_6", Q, 9'd100, 1'b0, 8'h00, N100, 1'b0);
        do_sample("s3_7", Q, 9'd100, 1'b0, 8'h00, N100, 1'b0);
        do_sample("s3_8", Q, 9'd100, 1'b0, 8'h00, P100, 1'b1);
        // request 'h00 in the same cycle as a wrapping strobe: pending only
        do_sample("s3_9",  Q, 9'd100, 1'b0, 8'h00, N100, 1'b0);
        do_sample("s3_10", Q, 9'd100, 1'b0, 8'h00, N100, 1'b0);
        do_sample("s3_11", Q, 9'd100, 1'b0, 8'h00, N100, 1'b0);
        do_sample("s3_12", Q, 9'd100, 1'b1, 8'h00, P100, 1'b1);
        do_sample("s3_13", Q, 9'd100, 1'b0, 8'h00, N100, 1'b0);
        do_sample("s3_14", Q, 9'd100, 1'b0, 8'h00, N100, 1'b0);
        do_sample("s3_15", Q, 9'd100, 1'b0, 8'h00, N100, 1'b0);
        // duty 0 now active: phase 'h00 is low
        do_sample("s3_16", Q, 9'd100, 1'b0, 8'h00, N100, 1'b1);

        // 4: rest mutes and restarts the phase; envelope 0; rest promotes pending duty
        apply_reset("s4");
        do_sample("s4_1", Q, 9'd100, 1'b0, 8'h00, P100, 1'b0);
        do_sample("s4_2", Q, 9'd100, 1'b0, 8'h00, N100, 1'b0);
        do_sample("s4_rest", 32'h0, 9'd100, 1'b0, 8'h00, 10'h000, 1'b0);
        do_sample("s4_restart", Q, 9'd100, 1'b0, 8'h00, P100, 1'b0);
        do_sample("s4_env0", Q, 9'd0, 1'b0, 8'h00, 10'h000, 1'b0);
        pulse_top(8'h20);
        do_sample("s4_rest2", 32'h0, 9'd50, 1'b0, 8'h00, 10'h000, 1'b0);
        do_sample("s4_d20a", 32'h1000_0000, 9'd50, 1'b0, 8'h00, P50, 1'b0);
        do_sample("s4_d20b", 32'h1000_0000, 9'd50, 1'b0, 8'h00, N50, 1'b0);

        // 5: back-to-back strobes, half-period delta, full-scale envelope
        apply_reset("s5");
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k >= 2 && k <= 7) begin
                check($sformatf("s5_valid%0d", k - 2), o_sample_valid, 1);
                check($sformatf("s5_sample%0d", k - 2), o_sample, ((k - 2) % 2 == 0) ? N511 : P511);
                check($sformatf("s5_wrap%0d", k - 2), o_wrap, ((k - 2) % 2 == 0) ? 0 : 1);
            end
            if (k == 8)
                check("s5_valid_end", o_sample_valid, 0);
            stb = (k <= 5);
            delta = 32'h8000_0000;
            env = 9'd511;
        end
        stb = 1'b0;

        // 6: reset one cycle after a strobe kills the in-flight sample
        apply_reset("s6");
        @(negedge clk);
        stb = 1'b1; delta = Q; env = 9'd100;
        @(negedge clk);
        stb = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check("s6_valid_in_rst", o_sample_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("s6_valid_post1", o_sample_valid, 0);
        check("s6_sample_post1", o_sample, 0);
        @(negedge clk);
        check("s6_valid_post2", o_sample_valid, 0);
        check("s6_wrap_post2", o_wrap, 0);
        do_sample("s6_first", Q, 9'd100, 1'b0, 8'h00, P100, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
